// File: rtl/fifo_pkg.sv
// Shared definitions for the read-side FIFO streamer and its elastic buffer.
package fifo_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int SKID_DEPTH     = 3;

  // Occupancy and pointer range of the elastic buffer (0..SKID_DEPTH).
  typedef logic [1:0] occ_t;

  // Advance a buffer pointer, wrapping from the last slot back to slot 0.
  function automatic occ_t ptr_inc(input occ_t p);
    return (p == occ_t'(SKID_DEPTH - 1)) ? occ_t'(0) : p + occ_t'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Three-entry elastic buffer between the FIFO read port and the output stream.
// The head word is held in its own register so the output never sees push_data
// combinationally.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output occ_t              occ,
  output logic [DATA_W-1:0] head_data
);

  logic [DATA_W-1:0] mem_q [SKID_DEPTH];
  occ_t              head_q, head_d;
  occ_t              tail_q, tail_d;
  occ_t              occ_q, occ_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;

  // Next pointers, occupancy and the word that will sit at the head next cycle.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    occ_d       = occ_q;
    head_data_d = head_data_q;

    if (push) tail_d = ptr_inc(tail_q);
    if (pop)  head_d = ptr_inc(head_q);

    case ({push, pop})
      2'b10:   occ_d = occ_q + occ_t'(1);
      2'b01:   occ_d = occ_q - occ_t'(1);
      default: occ_d = occ_q;
    endcase

    // Only refresh the head register when the next head slot holds a real
    // word; when the slot being written is the next head, bypass the array.
    if (occ_d != occ_t'(0)) begin
      if (push && (tail_q == head_d)) head_data_d = push_data;
      else                            head_data_d = mem_q[head_d];
    end
  end

  // Storage array: data only, no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= push_data;
  end

  // Pointer, occupancy and head-register state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      head_data_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
      head_data_q <= head_data_d;
    end
  end

  assign occ       = occ_q;
  assign head_data = head_data_q;

  // The upstream credit rule must never let a word arrive into a full buffer.
  overflow_chk: assert property (@(posedge clk) disable iff (!rstn)
    !(push && !pop && (occ_q == occ_t'(SKID_DEPTH))));

endmodule

// File: rtl/fifo_rd_streamer.sv
// Read-domain consumer of the async FIFO: pops words with a credit scheme that
// covers the FIFO's one-cycle read latency and re-presents them as a
// valid/ready stream with a delivered-word counter.
module fifo_rd_streamer
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic              r_clk,
  input  logic              rstn,
  input  logic              en,
  output logic              r_en,
  input  logic [DATA_W-1:0] r_data,
  input  logic              empty_flag,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  words_out,
  output logic              busy
);

  occ_t             occ;
  logic [2:0]       credit_used;
  logic             xfer;
  logic             pend_vld_p1_q, pend_vld_p1_d;
  logic [CNT_W-1:0] words_out_q, words_out_d;

  // Stage 0: issue a pop only when a buffer slot is guaranteed for its data.
  // m_ready does not appear here, so there is no combinational ready path.
  always_comb begin
    credit_used   = {1'b0, occ} + {2'b00, pend_vld_p1_q};
    r_en          = rstn & en & ~empty_flag & (credit_used < 3'(SKID_DEPTH));
    xfer          = m_valid & m_ready;
    pend_vld_p1_d = r_en;
    words_out_d   = words_out_q + CNT_W'(xfer);
  end

  // Stage 1: pop in flight (r_data valid this cycle) and delivered-word count.
  always_ff @(posedge r_clk) begin
    if (!rstn) begin
      pend_vld_p1_q <= 1'b0;
      words_out_q   <= '0;
    end else begin
      pend_vld_p1_q <= pend_vld_p1_d;
      words_out_q   <= words_out_d;
    end
  end

  // Stage 2: captured words wait in the elastic buffer until accepted.
  fifo_rd_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (r_clk),
    .rstn      (rstn),
    .push      (pend_vld_p1_q),
    .push_data (r_data),
    .pop       (xfer),
    .occ       (occ),
    .head_data (m_data)
  );

  assign m_valid   = (occ != occ_t'(0));
  assign busy      = m_valid | pend_vld_p1_q;
  assign words_out = words_out_q;

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer with a behavioural FIFO read port,
// a scoreboard queue of expected words and a negedge monitor.
module tb_fifo_rd_streamer;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  logic              r_clk = 1'b0;
  logic              rstn = 1'b0;
  logic              en = 1'b0;
  logic              m_ready = 1'b0;
  logic              force_empty = 1'b0;
  logic              fifo_clr = 1'b0;
  logic              empty_flag;
  logic              r_en, m_valid, busy;
  logic [DATA_W-1:0] r_data = '0;
  logic [DATA_W-1:0] m_data;
  logic [CNT_W-1:0]  words_out;

  always #5 r_clk = ~r_clk;

  fifo_rd_streamer #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .r_clk      (r_clk),
    .rstn       (rstn),
    .en         (en),
    .r_en       (r_en),
    .r_data     (r_data),
    .empty_flag (empty_flag),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .words_out  (words_out),
    .busy       (busy)
  );

  // Behavioural FIFO read port: one-cycle read latency.
  logic [DATA_W-1:0] fmem [256];
  logic [7:0]        wr_ptr = '0;
  logic [7:0]        rd_ptr = '0;

  assign empty_flag = force_empty | (rd_ptr == wr_ptr);

  always @(posedge r_clk) begin
    if (fifo_clr) rd_ptr <= wr_ptr;
    else if (r_en && !empty_flag) begin
      r_data <= fmem[rd_ptr];
      rd_ptr <= rd_ptr + 8'd1;
    end
  end

  logic [DATA_W-1:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  bit ren_h  [4096];
  bit xfer_h [4096];
  bit busy_h [4096];
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int cnt(input int kind, input int a, input int b);
    int n = 0;
    for (int i = a; i < b; i++) n += (kind == 0) ? int'(ren_h[i]) : int'(xfer_h[i]);
    return n;
  endfunction

  function automatic int first_of(input int kind, input int a, input int b);
    for (int i = a; i < b; i++)
      if (((kind == 0) ? ren_h[i] : xfer_h[i]) == 1'b1) return i;
    return -1;
  endfunction

  function automatic int last_of(input int kind, input int a, input int b);
    for (int i = b - 1; i >= a; i--)
      if (((kind == 0) ? ren_h[i] : xfer_h[i]) == 1'b1) return i;
    return -1;
  endfunction

  task automatic step();
    @(posedge r_clk);
    #1;
  endtask

  task automatic push_words(input int n, input logic [DATA_W-1:0] base);
    for (int i = 0; i < n; i++) begin
      fmem[wr_ptr] = DATA_W'(int'(base) + i);
      exp_q.push_back(DATA_W'(int'(base) + i));
      wr_ptr = wr_ptr + 8'd1;
    end
  endtask

  // Monitor: history recording, ordering, hold stability and counter tracking.
  initial begin
    logic [DATA_W-1:0] prev_data;
    bit                prev_stall;
    int                delivered;
    prev_data  = '0;
    prev_stall = 1'b0;
    delivered  = 0;
    forever begin
      @(negedge r_clk);
      ren_h[cyc]  = r_en;
      xfer_h[cyc] = m_valid & m_ready;
      busy_h[cyc] = busy;
      if (rstn) begin
        check("ren_while_empty", 32'(r_en & empty_flag), 32'd0);
        check("words_out_track", 32'(words_out), 32'(delivered[CNT_W-1:0]));
        if (prev_stall) begin
          check("hold_valid", 32'(m_valid), 32'd1);
          check("hold_data", 32'(m_data), 32'(prev_data));
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got %0h want none", m_data);
          end else begin
            check("data_order", 32'(m_data), 32'(exp_q.pop_front()));
          end
          delivered++;
        end
        prev_stall = m_valid & ~m_ready;
        prev_data  = m_data;
      end else begin
        delivered  = 0;
        prev_stall = 1'b0;
      end
      cyc++;
    end
  end

  // Directed stimulus.
  initial begin
    int t0, fr, lr, fx, lx;
    logic [15:0] emp_pat;
    emp_pat = 16'hB2D6;

    // Reset held with data available and en high.
    rstn = 1'b0; en = 1'b1; m_ready = 1'b1;
    push_words(16, 16'h0001);
    t0 = cyc;
    repeat (3) step();
    check("rst_ren_cnt", 32'(cnt(0, t0, cyc)), 32'd0);
    check("rst_r_en", 32'(r_en), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_words_out", 32'(words_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Streaming 16 words at one per cycle.
    rstn = 1'b1;
    t0 = cyc;
    repeat (30) step();
    fr = first_of(0, t0, cyc); lr = last_of(0, t0, cyc);
    fx = first_of(1, t0, cyc); lx = last_of(1, t0, cyc);
    check("first_ren_after_reset", 32'(fr), 32'(t0));
    check("stream_pops", 32'(cnt(0, t0, cyc)), 32'd16);
    check("stream_pop_span", 32'(lr - fr), 32'd15);
    check("stream_latency", 32'(fx - fr), 32'd2);
    check("stream_beats", 32'(cnt(1, t0, cyc)), 32'd16);
    check("stream_beat_span", 32'(lx - fx), 32'd15);
    check("busy_before_drop", 32'(busy_h[lr+2]), 32'd1);
    check("busy_after_drop", 32'(busy_h[lr+3]), 32'd0);
    check("stream_words_out", 32'(words_out), 32'd0);

    // Backpressure: only three pops fit, head held stable.
    m_ready = 1'b0;
    push_words(8, 16'h0101);
    t0 = cyc;
    repeat (10) step();
    check("bp_pops", 32'(cnt(0, t0, cyc)), 32'd3);
    check("bp_head", 32'(m_data), 32'h0101);
    check("bp_valid", 32'(m_valid), 32'd1);
    check("bp_ren_off", 32'(r_en), 32'd0);
    m_ready = 1'b1;
    t0 = cyc;
    repeat (15) step();
    check("bp_release_beats", 32'(cnt(1, t0, cyc)), 32'd8);
    check("bp_release_pops", 32'(cnt(0, t0, cyc)), 32'd5);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Empty boundary: idle, then a single word.
    t0 = cyc;
    repeat (4) step();
    check("empty_idle_pops", 32'(cnt(0, t0, cyc)), 32'd0);
    push_words(1, 16'h0BEE);
    t0 = cyc;
    repeat (6) step();
    check("single_pops", 32'(cnt(0, t0, cyc)), 32'd1);
    check("single_beats", 32'(cnt(1, t0, cyc)), 32'd1);
    check("single_latency", 32'(first_of(1, t0, cyc) - first_of(0, t0, cyc)), 32'd2);

    // empty_flag toggling while four words are queued.
    push_words(4, 16'h0C01);
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      force_empty = emp_pat[i];
      step();
    end
    force_empty = 1'b0;
    repeat (4) step();
    check("toggle_pops", 32'(cnt(0, t0, cyc)), 32'd4);
    check("toggle_beats", 32'(cnt(1, t0, cyc)), 32'd4);

    // en dropped after five pops, then raised again.
    push_words(10, 16'h0D01);
    t0 = cyc;
    repeat (5) step();
    en = 1'b0;
    repeat (10) step();
    check("en_off_pops", 32'(cnt(0, t0, cyc)), 32'd5);
    check("en_off_beats", 32'(cnt(1, t0, cyc)), 32'd5);
    check("en_off_ren", 32'(r_en), 32'd0);
    check("en_off_busy", 32'(busy), 32'd0);
    en = 1'b1;
    t0 = cyc;
    repeat (15) step();
    check("en_on_pops", 32'(cnt(0, t0, cyc)), 32'd5);
    check("en_on_beats", 32'(cnt(1, t0, cyc)), 32'd5);
    check("pre_wrap_words_out", 32'(words_out), 32'd7);

    // Counter wrap: 18 words into a 4-bit counter.
    rstn = 1'b0;
    repeat (2) step();
    rstn = 1'b1;
    push_words(18, 16'h0E01);
    t0 = cyc;
    repeat (30) step();
    check("wrap_beats", 32'(cnt(1, t0, cyc)), 32'd18);
    check("wrap_words_out", 32'(words_out), 32'd2);

    // Reset one cycle after a pop: the returning word is discarded.
    push_words(3, 16'h0F01);
    step();
    rstn = 1'b0;
    fifo_clr = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_ren", 32'(r_en), 32'd0);
    step();
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_m_data", 32'(m_data), 32'd0);
    check("midrst_words_out", 32'(words_out), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    fifo_clr = 1'b0;
    t0 = cyc;
    repeat (6) step();
    check("midrst_no_beats", 32'(cnt(1, t0, cyc)), 32'd0);
    check("midrst_no_pops", 32'(cnt(0, t0, cyc)), 32'd0);
    check("midrst_still_empty", 32'(m_valid), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
